branch_resolve_unit: RTL and testbench

Execute-stage counterpart to the fetch-stage branch predictor. Holds a FIFO of in-flight predictions (taken bit, predicted target, fall-through PC) pushed at fetch. When the execute stage resolves a branch/jump, pops the oldest entry and compares it with the actual outcome. On mismatch, drives the redirect (`Eval_branch`, `Redirect_PC`) and a pipeline flush; on every resolution, pulses `StateUpdateEnable` so the predictor's 2-bit counter trains on `PCSrcE`.

---
 rtl/branch_resolve_unit.sv | 104 ++++++++++
 tb/tb_branch_resolve_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: FIFO of fetch-time predictions checked against the
// actual outcome, producing redirect/flush, predictor training strobe and statistics.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_valid,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   input  logic [31:0]      pred_pc_plus4,
   output logic             pred_ready,
   input  logic             BranchE,
   input  logic             PCSrcE,
   input  logic [31:0]      Act_Target,
   output logic             Eval_branch,
   output logic [31:0]      Redirect_PC,
   output logic             flush,
   output logic             StateUpdateEnable,
   output logic             q_empty,
   output logic             underflow_err,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
   logic               taken_mem  [DEPTH];
   logic [31:0]        target_mem [DEPTH];
   logic [31:0]        pc4_mem    [DEPTH];
   logic               underflow_reg;
   logic [CNT_W-1:0]   branch_count_reg, mispredict_count_reg;

   logic               full, res, mis, push;
   logic [AW-1:0]      head_idx, tail_idx;
   logic               head_taken;
   logic [31:0]        head_target, head_pc4;

   assign head_idx    = rd_ptr_reg[AW-1:0];
   assign tail_idx    = wr_ptr_reg[AW-1:0];
   assign q_empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pred_ready  = ~full;

   assign head_taken  = taken_mem[head_idx];
   assign head_target = target_mem[head_idx];
   assign head_pc4    = pc4_mem[head_idx];

   // A taken/taken pair can still mispredict if the computed target differs.
   assign res  = BranchE & ~q_empty;
   assign mis  = res & ((head_taken != PCSrcE) |
                        (PCSrcE & head_taken & (head_target != Act_Target)));
   assign push = pred_valid & pred_ready & ~mis;

   assign Eval_branch       = mis;
   assign flush             = mis;
   assign StateUpdateEnable = res;
   assign Redirect_PC       = mis ? (PCSrcE ? Act_Target : head_pc4) : 32'h0;

   assign underflow_err     = underflow_reg;
   assign branch_count      = branch_count_reg;
   assign mispredict_count  = mispredict_count_reg;

   // Storage carries no reset; validity is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         taken_mem[tail_idx]  <= pred_taken;
         target_mem[tail_idx] <= pred_target;
         pc4_mem[tail_idx]    <= pred_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         // Every entry younger than a mispredicted branch is wrong-path.
         if (mis)
            rd_ptr_reg <= wr_ptr_reg;
         else if (res)
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_count_reg     <= '0;
         mispredict_count_reg <= '0;
         underflow_reg        <= 1'b0;
      end else begin
         if (res && (branch_count_reg != {CNT_W{1'b1}}))
            branch_count_reg <= branch_count_reg + CNT_W'(1);
         if (mis && (mispredict_count_reg != {CNT_W{1'b1}}))
            mispredict_count_reg <= mispredict_count_reg + CNT_W'(1);
         if (BranchE && q_empty)
            underflow_reg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_branch_resolve_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        pred_valid, pred_taken;
   logic [31:0] pred_target, pred_pc_plus4;
   logic        pred_ready;
   logic        BranchE, PCSrcE;
   logic [31:0] Act_Target;
   logic        Eval_branch, flush, StateUpdateEnable, q_empty, underflow_err;
   logic [31:0] Redirect_PC;
   logic [3:0]  branch_count, mispredict_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_tgt[$];
   logic [31:0] nt;
   logic [31:0] tgt;

   branch_resolve_unit #(.DEPTH(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_pc_plus4(pred_pc_plus4),
      .pred_ready(pred_ready),
      .BranchE(BranchE), .PCSrcE(PCSrcE), .Act_Target(Act_Target),
      .Eval_branch(Eval_branch), .Redirect_PC(Redirect_PC), .flush(flush),
      .StateUpdateEnable(StateUpdateEnable), .q_empty(q_empty),
      .underflow_err(underflow_err), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic t, input logic [31:0] tg, input logic [31:0] pc4);
      pred_valid = 1'b1; pred_taken = t; pred_target = tg; pred_pc_plus4 = pc4;
      cyc();
      pred_valid = 1'b0;
   endtask

   task automatic resolve_drive(input logic src, input logic [31:0] act);
      BranchE = 1'b1; PCSrcE = src; Act_Target = act;
      #2;
   endtask

   task automatic resolve_end();
      cyc();
      BranchE = 1'b0;
   endtask

   initial begin
      reset = 1'b0; pred_valid = 0; pred_taken = 0; pred_target = 0; pred_pc_plus4 = 0;
      BranchE = 0; PCSrcE = 0; Act_Target = 0;
      #12;
      chk("rst_q_empty", q_empty, 1);
      chk("rst_ready", pred_ready, 1);
      chk("rst_bc", branch_count, 0);
      chk("rst_mc", mispredict_count, 0);
      chk("rst_uf", underflow_err, 0);
      chk("rst_eval", Eval_branch, 0);
      chk("rst_sue", StateUpdateEnable, 0);
      chk("rst_redir", Redirect_PC, 0);
      cyc();
      reset = 1'b1;
      cyc();

      // correct not-taken
      push(1'b0, 32'h100, 32'h44);
      chk("nt_q_nonempty", q_empty, 0);
      resolve_drive(1'b0, 32'h0);
      chk("nt_sue", StateUpdateEnable, 1);
      chk("nt_eval", Eval_branch, 0);
      chk("nt_redir", Redirect_PC, 0);
      resolve_end();
      chk("nt_bc", branch_count, 1);
      chk("nt_mc", mispredict_count, 0);
      chk("nt_q_empty", q_empty, 1);

      // direction mispredict
      push(1'b1, 32'h200, 32'h48);
      resolve_drive(1'b0, 32'h200);
      chk("dir_eval", Eval_branch, 1);
      chk("dir_flush", flush, 1);
      chk("dir_redir", Redirect_PC, 32'h48);
      chk("dir_sue", StateUpdateEnable, 1);
      resolve_end();
      chk("dir_mc", mispredict_count, 1);
      chk("dir_bc", branch_count, 2);
      chk("dir_q_empty", q_empty, 1);

      // target mispredict with squash of younger entries and same-cycle push
      push(1'b1, 32'h300, 32'h4c);
      push(1'b0, 32'h400, 32'h50);
      push(1'b1, 32'h500, 32'h54);
      pred_valid = 1'b1; pred_taken = 1'b0; pred_target = 32'h600; pred_pc_plus4 = 32'h58;
      resolve_drive(1'b1, 32'h310);
      chk("tgt_eval", Eval_branch, 1);
      chk("tgt_redir", Redirect_PC, 32'h310);
      resolve_end();
      pred_valid = 1'b0;
      chk("tgt_q_empty", q_empty, 1);
      chk("tgt_mc", mispredict_count, 2);
      chk("tgt_bc", branch_count, 3);

      // fill, reject 5th push, then alternate pop/push across the wrap
      for (int i = 0; i < 4; i++) begin
         tgt = 32'h1000 + 32'(i) * 32'h10;
         push(1'b1, tgt, tgt + 32'h4);
         exp_tgt.push_back(tgt);
      end
      chk("full_ready", pred_ready, 0);
      push(1'b1, 32'hdead, 32'hbeef);
      chk("full_ready_after_5th", pred_ready, 0);
      nt = 32'h1040;
      for (int i = 0; i < 10; i++) begin
         tgt = exp_tgt.pop_front();
         resolve_drive(1'b1, tgt);
         chk("wrap_order", Eval_branch, 0);
         resolve_end();
         chk("wrap_ready_after_pop", pred_ready, 1);
         push(1'b1, nt, nt + 32'h4);
         exp_tgt.push_back(nt);
         nt = nt + 32'h10;
         chk("wrap_count4", pred_ready, 0);
      end
      chk("wrap_bc", branch_count, 13);
      for (int i = 0; i < 4; i++) begin
         tgt = exp_tgt.pop_front();
         resolve_drive(1'b1, tgt);
         chk("drain_order", Eval_branch, 0);
         resolve_end();
      end
      chk("drain_q_empty", q_empty, 1);
      chk("drain_bc_sat", branch_count, 15);
      chk("drain_mc", mispredict_count, 2);

      // underflow
      resolve_drive(1'b1, 32'h0);
      chk("uf_sue", StateUpdateEnable, 0);
      chk("uf_eval", Eval_branch, 0);
      resolve_end();
      chk("uf_flag", underflow_err, 1);
      chk("uf_bc", branch_count, 15);
      cyc();
      chk("uf_sticky", underflow_err, 1);

      // async reset mid-stream
      push(1'b1, 32'h700, 32'h704);
      push(1'b0, 32'h800, 32'h804);
      chk("ar_pre_nonempty", q_empty, 0);
      BranchE = 1'b1; PCSrcE = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("ar_q_empty", q_empty, 1);
      chk("ar_bc", branch_count, 0);
      chk("ar_mc", mispredict_count, 0);
      chk("ar_uf", underflow_err, 0);
      chk("ar_sue", StateUpdateEnable, 0);
      chk("ar_eval", Eval_branch, 0);
      BranchE = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();

      // saturation: 20 correct resolutions
      for (int i = 0; i < 20; i++) begin
         push(1'b0, 32'h900, 32'h904);
         resolve_drive(1'b0, 32'h0);
         resolve_end();
      end
      chk("sat_bc", branch_count, 15);
      chk("sat_mc", mispredict_count, 0);
      chk("sat_uf", underflow_err, 0);
      chk("sat_q_empty", q_empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
